imem_load_ctrl: RTL and testbench
=================================

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 Parameter: DEPTH, default 32, number of 32-bit words in the instruction memory; word addresses run 0..DEPTH-1.
REQ-002 clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 resetn  input  1  reset; synchronous, active-low.
REQ-004 load_start  input  1  request to (re)load the program from word 0.
REQ-005 run_go  input  1  release the core without loading; memory keeps its current contents.
REQ-006 byte_in  input  8  program byte stream, little-endian within each word.
REQ-007 byte_valid  input  1  byte_in holds a valid byte.
REQ-008 byte_ready  output  1  controller can accept a byte this cycle.
REQ-009 load_done  input  1  single-cycle pulse marking the end of the program stream.
REQ-010 pc  input  32  core byte program counter.
REQ-011 fetch_addr  output  32  word address driven to the memory read port.
REQ-012 mem_waddr  output  32  word address driven to the memory write port.
REQ-013 mem_wdata  output  32  assembled word driven to the memory write port.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 core_stall  output  1  holds the core while the controller is not in RUN.
REQ-016 words_loaded  output  32  count of words committed since the last load_start.
REQ-017 load_err  output  1  sticky flag: partial word padded, or load overflow.
REQ-018 fetch_fault  output  1  pc outside the memory range while in RUN.

Function
REQ-019 The FSM SHALL have four states: IDLE, COLLECT, COMMIT and RUN.
REQ-020 IDLE: core_stall=1 and byte_ready=0; load_start -> COLLECT; otherwise run_go -> RUN; load_start has priority over run_go.
REQ-021 COLLECT: byte_ready=1; a byte transfers only when byte_valid=1 and byte_ready=1.
REQ-022 Byte k (k=0..3) of a word SHALL land in mem_wdata bits [8k+7:8k]; the 4th transfer moves the FSM to COMMIT on the next edge.
REQ-023 COMMIT lasts exactly 1 cycle: mem_we=1, mem_waddr=word_ptr, byte_ready=0; word_ptr and words_loaded each increment by 1.
REQ-024 Write latency SHALL be 1 cycle: mem_we asserts in the cycle after the edge that captures the 4th byte.
REQ-025 After COMMIT: if word_ptr was DEPTH-1 -> RUN; else if done_pending -> RUN; else -> COLLECT.
REQ-026 load_done in COLLECT or COMMIT SHALL set done_pending; a byte transferred in the same cycle SHALL still be accepted.
REQ-027 COLLECT with done_pending, byte_cnt=0 and no transfer -> RUN.
REQ-028 COLLECT with done_pending, byte_cnt!=0 and no transfer: upper bytes zero-filled, load_err set, -> COMMIT, then -> RUN.
REQ-029 A byte_valid arriving after a full load (DEPTH words) SHALL be ignored (byte_ready=0) and SHALL set load_err.
REQ-030 RUN: core_stall=0, byte_ready=0; fetch_addr = pc[31:2], zero-extended.
REQ-031 RUN with pc[31:2] >= DEPTH: fetch_addr=0 and fetch_fault=1, combinationally.
REQ-032 Outside RUN: fetch_addr=0 and fetch_fault=0.
REQ-033 load_start in RUN, COLLECT or COMMIT -> COLLECT on the next edge, with word_ptr, byte_cnt, words_loaded, done_pending and load_err cleared; any word in progress is discarded.
REQ-034 mem_we SHALL never be asserted outside COMMIT.

Reset
REQ-035 When resetn=0 at an edge: state=IDLE; word_ptr, byte_cnt, words_loaded, mem_wdata, mem_waddr, done_pending and load_err all 0.
REQ-036 Outputs in reset: mem_we=0, byte_ready=0, core_stall=1, fetch_addr=0, fetch_fault=0.
REQ-037 Reset SHALL take effect mid-load or mid-COMMIT and abort any pending write; no write occurs in the cycle after reset.

Verification
REQ-038 Scenario: load_start, then bytes B3,00,20,00 -> exactly one mem_we pulse with mem_waddr=0, mem_wdata=0x002000B3; then load_done -> RUN, words_loaded=1.
REQ-039 Scenario: stream 32 words back-to-back -> waddr 0..31, each word written once; RUN entered after the 32nd COMMIT; a 33rd byte_valid sets load_err and is not written.
REQ-040 Scenario: 2 bytes AA,BB then load_done -> mem_wdata=0x0000BBAA written, load_err=1, RUN entered.
REQ-041 Scenario: in RUN, pc=0x8 -> fetch_addr=2; pc=0x80 with DEPTH=32 -> fetch_addr=0, fetch_fault=1.
REQ-042 Scenario: resetn low after 3 bytes of a word -> no mem_we pulse, IDLE, core_stall=1; run_go -> RUN with words_loaded=0.
REQ-043 Scenario: byte_valid throttled (gaps of 0-3 cycles) with load_done arriving together with the final byte -> all words correct, RUN entered after the last COMMIT.

Source files
------------

// File: rtl/imem_load_ctrl.sv
// Instruction memory loader: assembles a byte stream into 32-bit words,
// writes them to the instruction memory and then releases the core.
//
// Ports:
//   clock, resetn      clock and synchronous active-low reset
//   load_start, run_go (re)load the program from word 0 / run without loading
//   byte_in, byte_valid, byte_ready   little-endian program byte stream
//   load_done          pulse marking the end of the program stream
//   pc                 core byte program counter
//   fetch_addr         word address to the memory read port
//   mem_waddr, mem_wdata, mem_we      memory write port
//   core_stall         holds the core until the controller is in RUN
//   words_loaded       words committed since the last load_start
//   load_err           sticky: partial word padded or load overflow
//   fetch_fault        pc outside the memory while in RUN
module imem_load_ctrl #(
    parameter int DEPTH = 32
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        load_start,
    input  logic        run_go,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        load_done,
    input  logic [31:0] pc,
    output logic [31:0] fetch_addr,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        core_stall,
    output logic [31:0] words_loaded,
    output logic        load_err,
    output logic        fetch_fault
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        COMMIT,
        RUN
    } state_t;

    state_t      state;
    state_t      nxt;
    logic [31:0] word_ptr;
    logic [1:0]  byte_cnt;
    logic        done_pending;

    logic        xfer;
    logic        last_word;
    logic        full;
    logic [31:0] pc_word;
    logic        pc_in_range;
    logic        pc_unused;

    // byte_ready is a registered decode of COLLECT, so it is the handshake.
    assign xfer      = byte_valid && byte_ready;
    assign last_word = (word_ptr == DEPTH_W - 32'd1);
    assign full      = (word_ptr == DEPTH_W);

    assign pc_word     = {2'b00, pc[31:2]};
    assign pc_in_range = (pc_word < DEPTH_W);
    assign pc_unused   = ^pc[1:0];

    assign fetch_addr  = (state == RUN && pc_in_range) ? pc_word : 32'd0;
    assign fetch_fault = (state == RUN) && !pc_in_range;

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (load_start)
                    nxt = COLLECT;
                else if (run_go)
                    nxt = RUN;
            end
            COLLECT: begin
                if (load_start)
                    nxt = COLLECT;
                else if (xfer && byte_cnt == 2'd3)
                    nxt = COMMIT;
                else if (!xfer && done_pending)
                    nxt = (byte_cnt == 2'd0) ? RUN : COMMIT;
            end
            COMMIT: begin
                if (load_start)
                    nxt = COLLECT;
                else if (last_word || done_pending)
                    nxt = RUN;
                else
                    nxt = COLLECT;
            end
            RUN: begin
                if (load_start)
                    nxt = COLLECT;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state        <= IDLE;
            word_ptr     <= 32'd0;
            byte_cnt     <= 2'd0;
            words_loaded <= 32'd0;
            mem_wdata    <= 32'd0;
            mem_waddr    <= 32'd0;
            done_pending <= 1'b0;
            load_err     <= 1'b0;
            mem_we       <= 1'b0;
            byte_ready   <= 1'b0;
            core_stall   <= 1'b1;
        end else begin
            state      <= nxt;
            mem_we     <= (nxt == COMMIT);
            byte_ready <= (nxt == COLLECT);
            core_stall <= (nxt != RUN);

            if (load_start) begin
                // Restart: drop any half-built word and all load status.
                word_ptr     <= 32'd0;
                byte_cnt     <= 2'd0;
                words_loaded <= 32'd0;
                mem_wdata    <= 32'd0;
                done_pending <= 1'b0;
                load_err     <= 1'b0;
            end else begin
                unique case (state)
                    COLLECT: begin
                        if (load_done)
                            done_pending <= 1'b1;
                        if (xfer) begin
                            unique case (byte_cnt)
                                2'd0: mem_wdata[7:0]   <= byte_in;
                                2'd1: mem_wdata[15:8]  <= byte_in;
                                2'd2: mem_wdata[23:16] <= byte_in;
                                2'd3: mem_wdata[31:24] <= byte_in;
                            endcase
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3)
                                mem_waddr <= word_ptr;
                        end else if (done_pending && byte_cnt != 2'd0) begin
                            // Stream ended mid-word: pad the missing
                            // upper bytes with zero and flag it.
                            unique case (byte_cnt)
                                2'd1: mem_wdata[31:8]  <= 24'd0;
                                2'd2: mem_wdata[31:16] <= 16'd0;
                                2'd3: mem_wdata[31:24] <= 8'd0;
                                default: ;
                            endcase
                            byte_cnt  <= 2'd0;
                            load_err  <= 1'b1;
                            mem_waddr <= word_ptr;
                        end
                    end
                    COMMIT: begin
                        if (load_done)
                            done_pending <= 1'b1;
                        word_ptr     <= word_ptr + 32'd1;
                        words_loaded <= words_loaded + 32'd1;
                    end
                    IDLE, RUN: begin
                        // Bytes offered once memory is full are overflow.
                        if (byte_valid && full)
                            load_err <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: directed load scenarios with a
// write scoreboard fed by the stimulus and drained by a write monitor.
module tb_imem_load_ctrl;

    logic        clock;
    logic        resetn;
    logic        load_start;
    logic        run_go;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        load_done;
    logic [31:0] pc;
    logic [31:0] fetch_addr;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        core_stall;
    logic [31:0] words_loaded;
    logic        load_err;
    logic        fetch_fault;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] sb[$];

    imem_load_ctrl #(.DEPTH(32)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .load_start   (load_start),
        .run_go       (run_go),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .load_done    (load_done),
        .pc           (pc),
        .fetch_addr   (fetch_addr),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .core_stall   (core_stall),
        .words_loaded (words_loaded),
        .load_err     (load_err),
        .fetch_fault  (fetch_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Every write pulse must match the oldest expected write.
    always @(negedge clock) begin
        if (mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_we", {31'd0, mem_we}, 32'd0);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("waddr", mem_waddr, e[63:32]);
                check("wdata", mem_wdata, e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic pulse_done();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic done);
        int n;
        n = 0;
        while (byte_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50)
            check("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
        byte_valid = 1'b1;
        byte_in    = b;
        load_done  = done;
        tick();
        byte_valid = 1'b0;
        load_done  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic done,
                             input int max_gap);
        for (int k = 0; k < 4; k++) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++)
                tick();
            send_byte(w[8*k +: 8], done && (k == 3));
        end
    endtask

    task automatic wait_run(input string tag);
        int n;
        n = 0;
        while (core_stall !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check(tag, {31'd0, core_stall}, 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        resetn     = 1'b0;
        load_start = 1'b0;
        run_go     = 1'b0;
        byte_in    = 8'd0;
        byte_valid = 1'b0;
        load_done  = 1'b0;
        pc         = 32'd0;
        tick();
        tick();

        check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
        check("rst_core_stall", {31'd0, core_stall}, 32'd1);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_fetch_addr", fetch_addr, 32'd0);
        check("rst_fetch_fault", {31'd0, fetch_fault}, 32'd0);
        check("rst_words", words_loaded, 32'd0);
        check("rst_err", {31'd0, load_err}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_waddr", mem_waddr, 32'd0);
        resetn = 1'b1;
        tick();
        check("idle_stall", {31'd0, core_stall}, 32'd1);

        // Single word, load_done afterwards.
        pulse_start();
        check("collect_ready", {31'd0, byte_ready}, 32'd1);
        sb.push_back({32'd0, 32'h002000B3});
        send_byte(8'hB3, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h00, 1'b0);
        check("commit_we", {31'd0, mem_we}, 32'd1);
        check("commit_not_ready", {31'd0, byte_ready}, 32'd0);
        pulse_done();
        wait_run("s1_run");
        check("s1_words", words_loaded, 32'd1);
        check("s1_err", {31'd0, load_err}, 32'd0);
        check("s1_sb_empty", sb.size(), 32'd0);

        // Fetch address mapping in RUN.
        pc = 32'h8;
        #1;
        check("fetch_pc8", fetch_addr, 32'd2);
        check("fault_pc8", {31'd0, fetch_fault}, 32'd0);
        pc = 32'h7C;
        #1;
        check("fetch_pc7c", fetch_addr, 32'd31);
        check("fault_pc7c", {31'd0, fetch_fault}, 32'd0);
        pc = 32'h80;
        #1;
        check("fetch_pc80", fetch_addr, 32'd0);
        check("fault_pc80", {31'd0, fetch_fault}, 32'd1);
        pc = 32'd0;

        // Partial word padded with zeros.
        pulse_start();
        check("s2_words_clr", words_loaded, 32'd0);
        check("s2_stall", {31'd0, core_stall}, 32'd1);
        sb.push_back({32'd0, 32'h0000BBAA});
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        pulse_done();
        wait_run("s2_run");
        check("s2_err", {31'd0, load_err}, 32'd1);
        check("s2_words", words_loaded, 32'd1);
        check("s2_sb_empty", sb.size(), 32'd0);

        // Full 32-word load, then overflow byte.
        pulse_start();
        check("s3_err_clr", {31'd0, load_err}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            w = $urandom;
            sb.push_back({32'(i), w});
            send_word(w, 1'b0, 0);
        end
        wait_run("s3_run");
        check("s3_words", words_loaded, 32'd32);
        check("s3_err", {31'd0, load_err}, 32'd0);
        check("s3_sb_empty", sb.size(), 32'd0);
        byte_valid = 1'b1;
        byte_in    = 8'h55;
        check("s3_ovf_ready", {31'd0, byte_ready}, 32'd0);
        tick();
        byte_valid = 1'b0;
        check("s3_ovf_err", {31'd0, load_err}, 32'd1);
        check("s3_ovf_words", words_loaded, 32'd32);

        // Reset in the edge that would capture the 4th byte.
        pulse_start();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        byte_valid = 1'b1;
        byte_in    = 8'h44;
        resetn     = 1'b0;
        tick();
        byte_valid = 1'b0;
        check("s4_we", {31'd0, mem_we}, 32'd0);
        check("s4_stall", {31'd0, core_stall}, 32'd1);
        check("s4_ready", {31'd0, byte_ready}, 32'd0);
        resetn = 1'b1;
        tick();
        check("s4_we_after", {31'd0, mem_we}, 32'd0);
        check("s4_err", {31'd0, load_err}, 32'd0);
        run_go = 1'b1;
        tick();
        run_go = 1'b0;
        check("s4_run", {31'd0, core_stall}, 32'd0);
        check("s4_words", words_loaded, 32'd0);

        // load_start beats run_go in IDLE.
        resetn = 1'b0;
        tick();
        resetn     = 1'b1;
        load_start = 1'b1;
        run_go     = 1'b1;
        tick();
        load_start = 1'b0;
        run_go     = 1'b0;
        check("prio_ready", {31'd0, byte_ready}, 32'd1);
        check("prio_stall", {31'd0, core_stall}, 32'd1);

        // Throttled stream, load_done with the final byte.
        for (int i = 0; i < 5; i++) begin
            w = $urandom;
            sb.push_back({32'(i), w});
            send_word(w, i == 4, 3);
        end
        wait_run("s5_run");
        check("s5_words", words_loaded, 32'd5);
        check("s5_err", {31'd0, load_err}, 32'd0);
        check("s5_sb_empty", sb.size(), 32'd0);

        tick();
        tick();
        check("final_sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
